intc_ctrl: RTL and testbench



---
 rtl/intc_pkg.sv | 18 +
 rtl/intc_prio_enc.sv | 27 ++
 rtl/intc_ctrl.sv | 138 +++++++++++++
 tb/tb_intc_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/intc_pkg.sv
// intc_pkg: shared constants for the 8-source interrupt controller.
//   REG_*            register offsets decoded from AD[2:0]
//   VECTOR_VALID_BIT bit position of the valid flag in the VECTOR register
//   DEFAULT_NUM_SRC  default number of interrupt sources
package intc_pkg;

  localparam int DEFAULT_NUM_SRC = 8;

  localparam logic [2:0] REG_PEND   = 3'd0;
  localparam logic [2:0] REG_MASK   = 3'd1;
  localparam logic [2:0] REG_VECTOR = 3'd2;
  localparam logic [2:0] REG_MODE   = 3'd3;
  localparam logic [2:0] REG_SWSET  = 3'd4;
  localparam logic [2:0] REG_INSERV = 3'd5;

  localparam int VECTOR_VALID_BIT = 7;

endpackage

// File: rtl/intc_prio_enc.sv
// intc_prio_enc: combinational lowest-index-set priority encoder.
//   req   [NUM_SRC-1:0] request vector, bit 0 has highest priority
//   valid               at least one request bit set
//   idx   [2:0]         index of the lowest set bit (0 when !valid)
module intc_prio_enc
  import intc_pkg::*;
#(
  parameter int NUM_SRC = DEFAULT_NUM_SRC
) (
  input  logic [NUM_SRC-1:0] req,
  output logic               valid,
  output logic [2:0]         idx
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    valid = 1'b0;
    idx   = 3'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = 3'(i);
      end
    end
  end

endmodule

// File: rtl/intc_ctrl.sv
// intc_ctrl: prioritised interrupt controller on the CPU data bus.
//   clk          system clock
//   rst          asynchronous, active-high reset
//   AD[2:0]      register select (PEND, MASK, VECTOR, MODE, SWSET, INSERV)
//   DI[7:0]      write data from CPU
//   DO[7:0]      read data, combinational from AD and current state
//   rw           1 = read, 0 = write
//   cs           chip select
//   irq_in       raw asynchronous active-high source lines
//   intr         registered interrupt request to the CPU
// Build option: define INTC_NESTING_EN to let a higher-priority source
// interrupt one already in service. Without it only one source can be in
// service at a time and intr is held low while any source is in service.
module intc_ctrl
  import intc_pkg::*;
#(
  parameter int NUM_SRC     = DEFAULT_NUM_SRC,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         AD,
  input  logic [7:0]         DI,
  output logic [7:0]         DO,
  input  logic               rw,
  input  logic               cs,
  input  logic [NUM_SRC-1:0] irq_in,
  output logic               intr
);

  logic [NUM_SRC-1:0] sync_p [SYNC_STAGES];
  logic [NUM_SRC-1:0] prev_p;
  logic [NUM_SRC-1:0] pend, mask, mode, inserv;
  logic               rd_vec_prev;

  logic [NUM_SRC-1:0] sync, rise, eligible, di_src;
  logic [NUM_SRC-1:0] w1c, swset, mode_chg, clr, pend_edge, pend_d, inserv_d;
  logic [NUM_SRC-1:0] best_oh, ceil_oh;
  logic               wr_en, rd_vec, ack_strobe, ack, eoi, mask_wr, mode_wr;
  logic               best_vld, ceil_vld, vec_valid, intr_d;
  logic [2:0]         best_idx, ceil_idx;

  assign sync     = sync_p[SYNC_STAGES-1];
  assign rise     = sync & ~prev_p;
  assign eligible = pend & mask;
  assign di_src   = DI[NUM_SRC-1:0];

  intc_prio_enc #(.NUM_SRC(NUM_SRC)) u_best (
    .req   (eligible),
    .valid (best_vld),
    .idx   (best_idx)
  );

  intc_prio_enc #(.NUM_SRC(NUM_SRC)) u_ceil (
    .req   (inserv),
    .valid (ceil_vld),
    .idx   (ceil_idx)
  );

`ifdef INTC_NESTING_EN
  assign vec_valid = best_vld;
  assign intr_d    = best_vld & (~ceil_vld | (best_idx < ceil_idx));
`else
  // Single-level: nothing is offered while a source is in service.
  assign vec_valid = best_vld & ~ceil_vld;
  assign intr_d    = best_vld & ~ceil_vld;
`endif

  assign wr_en   = cs & ~rw;
  assign rd_vec  = cs & rw & (AD == REG_VECTOR);
  // Only the first cycle of a held VECTOR read acknowledges.
  assign ack_strobe = rd_vec & ~rd_vec_prev;
  assign ack     = ack_strobe & vec_valid;
  assign eoi     = wr_en & (AD == REG_INSERV);
  assign mask_wr = wr_en & (AD == REG_MASK);
  assign mode_wr = wr_en & (AD == REG_MODE);

  always_comb begin
    best_oh = '0;
    ceil_oh = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      best_oh[i] = best_vld & (best_idx == 3'(i));
      ceil_oh[i] = ceil_vld & (ceil_idx == 3'(i));
    end
  end

  assign w1c      = (wr_en && AD == REG_PEND)  ? di_src : '0;
  assign swset    = (wr_en && AD == REG_SWSET) ? di_src : '0;
  assign mode_chg = mode_wr ? (di_src ^ mode) : '0;

  // Set terms are OR-ed in after the clear so a coincident rise or SWSET wins.
  assign clr       = w1c | (ack ? best_oh : '0);
  assign pend_edge = (pend & ~clr) | rise | swset;
  assign pend_d    = ((mode & pend_edge) | (~mode & sync)) & ~mode_chg;
  assign inserv_d  = (inserv & ~(eoi ? ceil_oh : '0)) | (ack ? best_oh : '0);

  // Synchroniser / edge-detect stage, then state update stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_p[s] <= '0;
      prev_p      <= '0;
      pend        <= '0;
      mask        <= '0;
      mode        <= '0;
      inserv      <= '0;
      rd_vec_prev <= 1'b0;
      intr        <= 1'b0;
    end else begin
      sync_p[0] <= irq_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_p[s] <= sync_p[s-1];
      prev_p      <= sync;
      pend        <= pend_d;
      if (mask_wr) mask <= di_src;
      if (mode_wr) mode <= di_src;
      inserv      <= inserv_d;
      rd_vec_prev <= rd_vec;
      intr        <= intr_d;
    end
  end

  always_comb begin
    DO = '0;
    case (AD)
      REG_PEND:   DO[NUM_SRC-1:0] = pend;
      REG_MASK:   DO[NUM_SRC-1:0] = mask;
      REG_VECTOR: begin
        if (vec_valid) begin
          DO[VECTOR_VALID_BIT] = 1'b1;
          DO[2:0]              = best_idx;
        end
      end
      REG_MODE:   DO[NUM_SRC-1:0] = mode;
      REG_INSERV: DO[NUM_SRC-1:0] = inserv;
      default:    DO = '0;
    endcase
  end

endmodule

// File: tb/tb_intc_ctrl.sv
module tb_intc_ctrl;
  import intc_pkg::*;

  localparam int NSRC = 8;
  localparam int SS   = 2;
`ifdef INTC_NESTING_EN
  localparam bit         NEST       = 1'b1;
  localparam logic [7:0] EXP_VEC1   = 8'h81;
  localparam logic [7:0] EXP_INS_A  = 8'h0A;
  localparam logic [7:0] EXP_INS_B  = 8'h08;
`else
  localparam bit         NEST       = 1'b0;
  localparam logic [7:0] EXP_VEC1   = 8'h00;
  localparam logic [7:0] EXP_INS_A  = 8'h08;
  localparam logic [7:0] EXP_INS_B  = 8'h00;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] AD = 3'd0;
  logic [7:0] DI = 8'h00;
  logic [7:0] DO;
  logic       rw = 1'b1;
  logic       cs = 1'b0;
  logic [7:0] irq_in = 8'h00;
  logic       intr;

  int errors = 0;
  int checks = 0;

  intc_ctrl #(.NUM_SRC(NSRC), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .AD(AD), .DI(DI), .DO(DO),
    .rw(rw), .cs(cs), .irq_in(irq_in), .intr(intr)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_pend, m_mask, m_mode, m_insrv, m_prev;
  bit         m_intr, m_rdprev;
  logic [7:0] m_hist [$];

  function automatic int lowest(logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 8;
  endfunction

  function automatic bit m_vvalid();
    return ((m_pend & m_mask) != 0) && (NEST || m_insrv == 0);
  endfunction

  function automatic logic [7:0] m_do(logic [2:0] a);
    case (a)
      3'd0: return m_pend;
      3'd1: return m_mask;
      3'd2: return m_vvalid() ? (8'h80 | 8'(lowest(m_pend & m_mask))) : 8'h00;
      3'd3: return m_mode;
      3'd5: return m_insrv;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [7:0] syn, rise, np, ni, elig;
    int b, c;
    bit wr, ack;
    if (rst) begin
      m_pend = 0; m_mask = 0; m_mode = 0; m_insrv = 0; m_prev = 0;
      m_intr = 0; m_rdprev = 0;
      m_hist = {};
      for (int k = 0; k < SS; k++) m_hist.push_back(8'h00);
    end else begin
      syn  = m_hist[0];
      rise = syn & ~m_prev;
      elig = m_pend & m_mask;
      b    = lowest(elig);
      c    = lowest(m_insrv);
      wr   = cs && !rw;
      ack  = cs && rw && (AD == 3'd2) && !m_rdprev && m_vvalid();
      np   = 0;
      for (int i = 0; i < 8; i++) begin
        if (!m_mode[i]) np[i] = syn[i];
        else if (rise[i] || (wr && AD == 3'd4 && DI[i])) np[i] = 1'b1;
        else if ((wr && AD == 3'd0 && DI[i]) || (ack && b == i)) np[i] = 1'b0;
        else np[i] = m_pend[i];
        if (wr && AD == 3'd3 && DI[i] != m_mode[i]) np[i] = 1'b0;
      end
      ni = m_insrv;
      if (wr && AD == 3'd5 && c < 8) ni[c] = 1'b0;
      if (ack) ni[b] = 1'b1;
      m_intr   = (elig != 0) && (m_insrv == 0 || (NEST && b < c));
      m_rdprev = cs && rw && (AD == 3'd2);
      if (wr && AD == 3'd1) m_mask = DI;
      if (wr && AD == 3'd3) m_mode = DI;
      m_pend  = np;
      m_insrv = ni;
      m_prev  = syn;
      m_hist.push_back(irq_in);
      void'(m_hist.pop_front());
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst) begin
      chk("cyc_intr", {7'b0, intr}, {7'b0, m_intr});
      chk("cyc_DO", DO, m_do(AD));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(logic [2:0] a, logic [7:0] d);
    cs = 1'b1; rw = 1'b0; AD = a; DI = d;
    step();
    cs = 1'b0; rw = 1'b1; DI = 8'h00;
  endtask

  task automatic peek(string nm, logic [2:0] a, logic [7:0] e);
    AD = a; #1;
    chk(nm, DO, e);
  endtask

  task automatic rdvec(string nm, logic [7:0] e);
    cs = 1'b1; rw = 1'b1; AD = 3'd2; #1;
    chk(nm, DO, e);
    step();
    cs = 1'b0;
  endtask

  task automatic chk_intr(string nm, bit e);
    chk(nm, {7'b0, intr}, {7'b0, e});
  endtask

  task automatic pulse(int s);
    irq_in[s] = 1'b1;
    step();
    irq_in[s] = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    step(3);
    peek("rst_pend", 3'd0, 8'h00);
    peek("rst_mask", 3'd1, 8'h00);
    chk_intr("rst_intr", 1'b0);
    rst = 1'b0;
    step(1);
    peek("rel_vec", 3'd2, 8'h00);
    peek("rel_mode", 3'd3, 8'h00);

    // 1: edge source 0 latency, ack and EOI
    wr(3'd1, 8'h01);
    wr(3'd3, 8'h01);
    pulse(0);
    step(1);
    peek("t1_pend_e2", 3'd0, 8'h00);
    step(1);
    peek("t1_pend_e3", 3'd0, 8'h01);
    chk_intr("t1_intr_e3", 1'b0);
    step(1);
    chk_intr("t1_intr_e4", 1'b1);
    rdvec("t1_vec", 8'h80);
    peek("t1_pend_ack", 3'd0, 8'h00);
    peek("t1_insrv_ack", 3'd5, 8'h01);
    step(1);
    chk_intr("t1_intr_drop", 1'b0);
    wr(3'd5, 8'h00);
    peek("t1_insrv_eoi", 3'd5, 8'h00);

    // 2: level source 2
    wr(3'd3, 8'h00);
    wr(3'd1, 8'h04);
    irq_in[2] = 1'b1;
    step(4);
    chk_intr("t2_intr", 1'b1);
    rdvec("t2_vec", 8'h82);
    step(1);
    chk_intr("t2_intr_svc", 1'b0);
    peek("t2_insrv", 3'd5, 8'h04);
    wr(3'd5, 8'h00);
    chk_intr("t2_intr_eoi", 1'b0);
    step(1);
    chk_intr("t2_intr_reassert", 1'b1);
    irq_in[2] = 1'b0;
    step(2);
    peek("t2_pend_hold", 3'd0, 8'h04);
    step(1);
    peek("t2_pend_drop", 3'd0, 8'h00);
    step(1);
    chk_intr("t2_intr_drop", 1'b0);

    // 3/4: nesting behaviour
    wr(3'd1, 8'h00);
    wr(3'd3, 8'h2A);
    wr(3'd1, 8'h2A);
    pulse(3);
    step(3);
    chk_intr("t3_intr3", 1'b1);
    rdvec("t3_vec3", 8'h83);
    step(1);
    chk_intr("t3_intr_svc3", 1'b0);
    peek("t3_insrv3", 3'd5, 8'h08);
    pulse(1);
    step(3);
    chk_intr("t3_intr_src1", NEST);
    rdvec("t3_vec1", EXP_VEC1);
    step(1);
    peek("t3_insrv_a", 3'd5, EXP_INS_A);
    wr(3'd5, 8'h00);
    peek("t3_insrv_b", 3'd5, EXP_INS_B);
`ifndef INTC_NESTING_EN
    step(1);
    chk_intr("t4_intr_after_eoi", 1'b1);
    rdvec("t4_vec1", 8'h81);
    wr(3'd5, 8'h00);
    pulse(3);
    step(3);
    rdvec("t4_vec3", 8'h83);
`endif
    pulse(5);
    step(3);
    chk_intr("t3_src5_blocked", 1'b0);
    step(1);
    chk_intr("t3_src5_blocked2", 1'b0);
    wr(3'd5, 8'h00);
    step(1);
    chk_intr("t3_src5_after_eoi", 1'b1);
    rdvec("t3_vec5", 8'h85);
    wr(3'd5, 8'h00);
    peek("t3_insrv_end", 3'd5, 8'h00);

    // 5a: W1C collides with a new rise on source 0
    wr(3'd1, 8'h00);
    wr(3'd3, 8'h01);
    pulse(0);
    step(3);
    peek("t5_pend_set", 3'd0, 8'h01);
    irq_in[0] = 1'b1;
    step(1);
    irq_in[0] = 1'b0;
    step(1);
    wr(3'd0, 8'h01);
    peek("t5_w1c_vs_rise", 3'd0, 8'h01);
    wr(3'd0, 8'h01);
    peek("t5_w1c_plain", 3'd0, 8'h00);

    // 5b: VECTOR read held for three cycles
    wr(3'd1, 8'h01);
    pulse(0);
    step(3);
    chk_intr("t5_intr", 1'b1);
    cs = 1'b1; rw = 1'b1; AD = 3'd2; #1;
    chk("t5_vec_first", DO, 8'h80);
    step(3);
    cs = 1'b0;
    peek("t5_insrv_once", 3'd5, 8'h01);
    peek("t5_pend_acked", 3'd0, 8'h00);
    wr(3'd5, 8'h00);

    // 6: SWSET then asynchronous reset mid-service
    wr(3'd1, 8'h00);
    wr(3'd3, 8'h10);
    wr(3'd1, 8'h10);
    wr(3'd4, 8'h10);
    step(1);
    chk_intr("t6_intr", 1'b1);
    rdvec("t6_vec", 8'h84);
    rst = 1'b1;
    #1;
    chk_intr("t6_rst_intr", 1'b0);
    peek("t6_rst_pend", 3'd0, 8'h00);
    peek("t6_rst_mask", 3'd1, 8'h00);
    peek("t6_rst_mode", 3'd3, 8'h00);
    peek("t6_rst_insrv", 3'd5, 8'h00);
    step(2);
    rst = 1'b0;
    step(2);
    peek("t6_post_vec", 3'd2, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
